cv32e40s_clint_irq_ctrl: RTL

CV32E40S_CLINT_IRQ_CTRL -- requirements
Module: cv32e40s_clint_irq_ctrl

---
 rtl/cv32e40s_pkg.sv | 17 +
 rtl/cv32e40s_sync.sv | 23 ++
 rtl/cv32e40s_clint_irq_ctrl.sv | 90 +++++++++
 3 files changed

// File: rtl/cv32e40s_pkg.sv
// Shared types and constants for the CLINT interrupt controller slice.
package cv32e40s_pkg;

    typedef enum logic [1:0] {
        PRIV_LVL_U = 2'b00,
        PRIV_LVL_S = 2'b01,
        PRIV_LVL_H = 2'b10,
        PRIV_LVL_M = 2'b11
    } privlvl_t;

    // Interrupt lines implemented in mip/mie: MSI, MTI, MEI and the 16 platform lines.
    localparam logic [31:0] IRQ_MASK    = 32'hFFFF_0888;
    localparam int unsigned CSR_MSI_BIT = 3;
    localparam int unsigned CSR_MTI_BIT = 7;
    localparam int unsigned CSR_MEI_BIT = 11;

endpackage

// File: rtl/cv32e40s_sync.sv
// Multi-flop synchronizer for one asynchronous level signal.
module cv32e40s_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic serial_i,
    output logic serial_o
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], serial_i};
        end
    end

    assign serial_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/cv32e40s_clint_irq_ctrl.sv
// CLINT-mode interrupt controller: synchronizes irq lines, builds mip and
// presents a registered request/ID/wakeup to the core controller.
module cv32e40s_clint_irq_ctrl
    import cv32e40s_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] irq_i,
    input  logic [31:0] mie_i,
    input  logic        mstatus_mie_i,
    input  privlvl_t    priv_lvl_i,
    input  logic        irq_mask_i,
    output logic [31:0] mip_o,
    output logic        irq_req_ctrl_o,
    output logic [9:0]  irq_id_ctrl_o,
    output logic        irq_wu_ctrl_o
);

    logic [31:0] irq_sync;
    logic [31:0] pend_en;
    logic        global_en;
    logic [4:0]  win_id;
    logic        irq_req_d, irq_req_q;
    logic [9:0]  irq_id_d,  irq_id_q;
    logic        irq_wu_d,  irq_wu_q;
    logic        unused_irq;

    generate
        for (genvar gi = 0; gi < 32; gi++) begin : g_irq
            if (IRQ_MASK[gi]) begin : g_valid
                cv32e40s_sync #(
                    .SYNC_STAGES (SYNC_STAGES)
                ) u_sync (
                    .clk      (clk),
                    .rst_n    (rst_n),
                    .serial_i (irq_i[gi]),
                    .serial_o (irq_sync[gi])
                );
            end else begin : g_tie
                assign irq_sync[gi] = 1'b0;
            end
        end
    endgenerate

    assign unused_irq = ^(irq_i & ~IRQ_MASK);

    assign mip_o     = irq_sync;
    assign pend_en   = irq_sync & mie_i & IRQ_MASK;
    assign global_en = (priv_lvl_i == PRIV_LVL_U) ||
                       ((priv_lvl_i == PRIV_LVL_M) && mstatus_mie_i);

    // Lowest priority assigned first so later (higher priority) hits override.
    always_comb begin
        win_id = 5'd0;
        if (pend_en[CSR_MTI_BIT]) win_id = 5'(CSR_MTI_BIT);
        if (pend_en[CSR_MSI_BIT]) win_id = 5'(CSR_MSI_BIT);
        if (pend_en[CSR_MEI_BIT]) win_id = 5'(CSR_MEI_BIT);
        for (int i = 16; i < 32; i++) begin
            if (pend_en[i]) win_id = 5'(i);
        end
    end

    always_comb begin
        irq_wu_d  = |pend_en;
        irq_req_d = (|pend_en) && global_en && !irq_mask_i;
        irq_id_d  = irq_id_q;
        if (|pend_en) begin
            irq_id_d = {5'd0, win_id};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_req_q <= 1'b0;
            irq_id_q  <= 10'd0;
            irq_wu_q  <= 1'b0;
        end else begin
            irq_req_q <= irq_req_d;
            irq_id_q  <= irq_id_d;
            irq_wu_q  <= irq_wu_d;
        end
    end

    assign irq_req_ctrl_o = irq_req_q;
    assign irq_id_ctrl_o  = irq_id_q;
    assign irq_wu_ctrl_o  = irq_wu_q;

endmodule
